// File: rtl/controlador_sinc_vga.sv
// 640x480@60 VGA timing generator: pixel-rate divider, H/V counters and
// registered sync/blanking decode, all derived from the next counter state.
module controlador_sinc_vga #(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pixel_tick,
  output logic [9:0] cuenta_h,
  output logic [9:0] cuenta_v,
  output logic       Hsinc,
  output logic       Vsinc,
  output logic       video_on,
  output logic       inicio_cuadro
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0]    H_SS    = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]    H_SE    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    V_SS    = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]    V_SE    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div, div_n;
  logic [9:0]    h_n, v_n;
  logic          activo, activo_n;

  // The first enabled edge only loads the origin, so the first pixel lasts DIV clk.
  always_comb begin
    div_n    = '0;
    h_n      = '0;
    v_n      = '0;
    activo_n = 1'b0;
    if (en) begin
      activo_n = 1'b1;
      if (activo) begin
        h_n = cuenta_h;
        v_n = cuenta_v;
        if (div == DIV_MAX) begin
          if (cuenta_h == H_MAX) begin
            h_n = '0;
            v_n = (cuenta_v == V_MAX) ? 10'd0 : cuenta_v + 10'd1;
          end else begin
            h_n = cuenta_h + 10'd1;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      activo        <= 1'b0;
      div           <= '0;
      cuenta_h      <= '0;
      cuenta_v      <= '0;
      pixel_tick    <= 1'b0;
      Hsinc         <= 1'b1;
      Vsinc         <= 1'b1;
      video_on      <= 1'b0;
      inicio_cuadro <= 1'b0;
    end else begin
      activo        <= activo_n;
      div           <= div_n;
      cuenta_h      <= h_n;
      cuenta_v      <= v_n;
      pixel_tick    <= activo_n && (div_n == DIV_MAX);
      Hsinc         <= !(activo_n && (h_n >= H_SS) && (h_n <= H_SE));
      Vsinc         <= !(activo_n && (v_n >= V_SS) && (v_n <= V_SE));
      video_on      <= activo_n && (h_n < H_VIS) && (v_n < V_VIS);
      inicio_cuadro <= activo_n && (div_n == '0) && (h_n == '0) && (v_n == '0);
    end
  end
endmodule

// File: tb/tb_controlador_sinc_vga.sv
// Randomized enable/reset stimulus on a default-timing instance and a small
// DIV=1 instance, both checked every cycle against an arithmetic timing model.
module tb_controlador_sinc_vga;
  logic clk = 1'b0;
  logic rst_n, en;
  logic chk_on = 1'b0;
  int   n_tests = 0, n_fail = 0;

  logic       tick_a, hs_a, vs_a, von_a, ini_a;
  logic [9:0] h_a, v_a;
  logic       tick_b, hs_b, vs_b, von_b, ini_b;
  logic [9:0] h_b, v_b;

  always #5 clk = ~clk;

  controlador_sinc_vga dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(tick_a),
    .cuenta_h(h_a), .cuenta_v(v_a), .Hsinc(hs_a), .Vsinc(vs_a),
    .video_on(von_a), .inicio_cuadro(ini_a)
  );

  // Tiny geometry: 32 px/line, 19 lines/frame, one clk per pixel.
  controlador_sinc_vga #(
    .DIV(1), .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(tick_b),
    .cuenta_h(h_b), .cuenta_v(v_b), .Hsinc(hs_b), .Vsinc(vs_b),
    .video_on(von_b), .inicio_cuadro(ini_b)
  );

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t obs{h,v,tick,hs,vs,von,ini}=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // Model: clocks elapsed since the enable edge determine every output.
  function automatic logic [24:0] esp(input int t, input bit act, input int dv,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb);
    int ht, vt, p, h, v;
    logic tk, hsn, vsn, von, ini;
    if (!act) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    p   = t / dv;
    h   = p % ht;
    v   = (p / ht) % vt;
    tk  = (t % dv) == dv - 1;
    hsn = !(h >= hv + hf && h < hv + hf + hs);
    vsn = !(v >= vv + vf && v < vv + vf + vs);
    von = (h < hv) && (v < vv);
    ini = (t % (dv * ht * vt)) == 0;
    return {10'(h), 10'(v), tk, hsn, vsn, von, ini};
  endfunction

  bit m_act = 1'b0;
  int m_t   = 0;

  always @(posedge clk) begin
    if (!rst_n || !en) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else if (!m_act) begin
      m_act <= 1'b1;
      m_t   <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dflt", {h_a, v_a, tick_a, hs_a, vs_a, von_a, ini_a},
          esp(m_t, m_act, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      chk("div1", {h_b, v_b, tick_b, hs_b, vs_b, von_b, ini_b},
          esp(m_t, m_act, 1, 20, 3, 5, 4, 12, 2, 2, 3));
    end
  end

  // Inputs change 2 time units after an edge, well away from both edges.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    step(1);
    chk_on = 1'b1;
    step(4);
    rst_n = 1'b1;
    // Line 3, pixel ~700 on the default instance: inside hsync.
    step(12400);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2000);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(1300);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: step($urandom_range(1, 1500));
        1: begin
          en = 1'b0;
          step($urandom_range(1, 15));
          en = 1'b1;
          step($urandom_range(1, 900));
        end
        2: begin
          rst_n = 1'b0;
          en    = 1'($urandom_range(0, 1));
          step($urandom_range(1, 4));
          rst_n = 1'b1;
          en    = 1'b1;
          step($urandom_range(1, 900));
        end
        default: begin
          en = 1'b0;
          step(1);
          en = 1'b1;
          step($urandom_range(1, 700));
        end
      endcase
    end
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
